// File: rtl/pixel_histogram.sv
// Pixel histogram front end for the cell classifier: bins a valid/ready grayscale stream into
// a 64-bin intensity histogram, snapshots the feature bins at end of frame and pulses
// start_classification. A registered debug port reads any live bin.
module pixel_histogram #(
  parameter int unsigned NUM_PIXELS = 4096,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BIN_SHIFT  = 2,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] pixel_data,
  output logic             pixel_ready,
  output logic [CNT_W-1:0] bin_0,
  output logic [CNT_W-1:0] bin_34,
  output logic [CNT_W-1:0] bin_38,
  output logic [CNT_W-1:0] bin_39,
  output logic             start_classification,
  output logic             busy,
  output logic             hist_saturated,
  input  logic [5:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data
);

  localparam int unsigned BinW    = PIX_W - BIN_SHIFT;
  localparam int unsigned NumBins = 2 ** BinW;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [15:0] LastCnt = 16'(NUM_PIXELS);

  typedef enum logic [1:0] {StIdle, StAccum, StSnap, StDone} state_e;

  state_e state_q;

  logic [CNT_W-1:0] bins_q [NumBins];
  logic [CNT_W-1:0] bins_d [NumBins];
  logic [15:0]      cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic            accept;
  logic            clear;
  logic            last_pix;
  logic [BinW-1:0] bin_idx;

  // pixel_ready is a registered copy of (state == StAccum), so it gates acceptance directly
  assign accept   = pixel_valid && pixel_ready;
  assign clear    = frame_start && ((state_q == StIdle) || (state_q == StAccum));
  assign bin_idx  = BinW'(pixel_data >> BIN_SHIFT);
  assign last_pix = accept && (cnt_d == LastCnt);

  // Next histogram state: clear first, so a pixel accepted with a restart lands in the new frame
  always_comb begin
    bins_d = bins_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (clear) begin
      for (int b = 0; b < NumBins; b++) bins_d[b] = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end
    if (accept) begin
      if (bins_d[bin_idx] == CntMax) begin
        sat_d = 1'b1;
      end else begin
        bins_d[bin_idx] = bins_d[bin_idx] + 1'b1;
      end
      cnt_d = cnt_d + 16'd1;
    end
  end

  // Histogram storage, pixel counter, saturation flag and debug read register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NumBins; b++) bins_q[b] <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      rd_data <= '0;
    end else begin
      bins_q  <= bins_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      rd_data <= bins_q[rd_addr];
    end
  end

  // Frame FSM with registered handshake, snapshot and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= StIdle;
      pixel_ready          <= 1'b0;
      busy                 <= 1'b0;
      start_classification <= 1'b0;
      bin_0                <= '0;
      bin_34               <= '0;
      bin_38               <= '0;
      bin_39               <= '0;
      hist_saturated       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q     <= StAccum;
            pixel_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StAccum: begin
          if (last_pix) begin
            state_q     <= StSnap;
            pixel_ready <= 1'b0;
          end
        end
        StSnap: begin
          // Live bins are final here; the snapshot and pulse appear together in DONE
          state_q              <= StDone;
          bin_0                <= bins_q[0];
          bin_34               <= bins_q[34];
          bin_38               <= bins_q[38];
          bin_39               <= bins_q[39];
          hist_saturated       <= sat_q;
          start_classification <= 1'b1;
        end
        StDone: begin
          state_q              <= StIdle;
          start_classification <= 1'b0;
          busy                 <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          pixel_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pixel_histogram.md
# pixel_histogram

Upstream stage of the malaria-cell decision-tree classifier. Consumes one grayscale image as a valid/ready pixel stream and bins each pixel into a 64-bin intensity histogram. When the frame is complete, presents the four feature bins that the classifier uses (0, 34, 38, 39) as stable registered outputs, then issues a one-cycle `start_classification` pulse. Also provides a registered read port so that debug logic can dump any bin.

## Interface
- `NUM_PIXELS`, default 4096: pixels per frame (64x64); range 1..65535.
- `PIX_W`, default 8: pixel width.
- `BIN_SHIFT`, default 2: bin index is `pixel_data >> BIN_SHIFT`, giving 2^(PIX_W-BIN_SHIFT) = 64 bins.
- `CNT_W`, default 12: bin counter width.

Ports:
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `frame_start`, in, 1: starts or restarts a frame by clearing the histogram.
- `pixel_valid`, in, 1: `pixel_data` is valid.
- `pixel_data`, in, PIX_W: pixel intensity.
- `pixel_ready`, out, 1: high only in ACCUM; a pixel is accepted when `pixel_valid && pixel_ready`.
- `bin_0`, `bin_34`, `bin_38`, `bin_39`, out, CNT_W each: snapshot of the named bins from the last completed frame.
- `start_classification`, out, 1: one-cycle pulse when the snapshot is valid.
- `busy`, out, 1: high when state is not IDLE.
- `hist_saturated`, out, 1: at least one bin saturated in the last snapshotted frame.
- `rd_addr`, in, 6: debug bin select.
- `rd_data`, out, CNT_W: live count of bin `rd_addr`, with one-cycle latency.

## Operation
- Storage is 64 registers of CNT_W bits.
- States and transitions:
  - IDLE -> ACCUM on `frame_start`.
  - ACCUM -> SNAP on the accepted pixel that makes the count reach `NUM_PIXELS`.
  - SNAP -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- `frame_start` in IDLE: all bins, the pixel counter and the internal saturation flag clear at that edge. No pixel is accepted in that cycle.
- ACCUM, pixel accepted: bin[`pixel_data >> BIN_SHIFT`] increments and the pixel counter (16 bits) increments.
- Saturation: an increment of a bin already at 2^CNT_W-1 holds that bin at its value and sets the internal saturation flag. The pixel still counts toward `NUM_PIXELS`.
- `frame_start` in ACCUM (restart): bins and the counter clear. If a pixel is also accepted in that cycle, it becomes the first pixel of the new frame: its bin ends at 1 and the counter at 1.
- `frame_start` in SNAP or DONE is ignored. A new frame may start from IDLE on the following cycle.
- SNAP: `bin_0`, `bin_34`, `bin_38`, `bin_39` and `hist_saturated` load from the live bins and the flag.
- DONE: `start_classification` = 1. It is a registered output, high for exactly this cycle.
- Snapshot outputs hold until the next SNAP. Neither a restart nor a new frame alters them before that.
- `rd_data` is registered from bin[`rd_addr`] every cycle in all states.
- Reset: state = IDLE, all bins = 0, pixel counter = 0, and every output = 0 (`pixel_ready`, the snapshot bins, `start_classification`, `busy`, `hist_saturated`, `rd_data`). Reset mid-frame discards the frame with no pulse.

## Timing
- Throughput: one pixel per cycle in ACCUM, with no bubbles.
- Take cycle N as the cycle in which the last pixel is accepted:
  - N+1: state is SNAP and the live bins are final.
  - N+2: the snapshot outputs are valid, `start_classification` = 1 and state is DONE.
  - N+3: state is IDLE with `pixel_ready` = 0.
- The snapshot is stable from N+2 onward. The classifier samples the pulse and reads the bins in later cycles.
- `pixel_ready` drops at the edge that ends cycle N, so no pixel beyond `NUM_PIXELS` is accepted.
- `busy` = 1 in ACCUM, SNAP and DONE.
- `NUM_PIXELS` = 1: the single accepted pixel goes directly to SNAP.

## Test plan
- Ramp of 4096 pixels with values 0..255, each repeated 16 times: every bin is 64. Snapshot outputs are 64/64/64/64, `start_classification` pulses once at N+2 and `hist_saturated` = 0.
- 4096 pixels of value 0: `bin_0` = 4095 and `hist_saturated` = 1; the other outputs are 0. This exceeds the classifier's 1638 threshold.
- Mixed frame with 20 pixels of 152, 12 of 156, 5 of 136 and 4059 of 0:
  - Bins come out as `bin_38` = 20, `bin_39` = 12, `bin_34` = 5, `bin_0` = 4059.
  - Randomly deassert `pixel_valid` during the frame; the counts must be unchanged.
- Restart at pixel 100 with `frame_start` and `pixel_valid` both high and pixel = 4: the final counts cover only the new frame, including that pixel (`bin_1` is read via `rd_addr`). Exactly one pulse is issued.
- Assert `rst` at pixel 2000: all outputs go to 0 and no pulse is issued. A following full frame completes normally.
- Back-to-back frames, asserting `frame_start` in SNAP/DONE and then in the IDLE cycle: the SNAP/DONE assertions are ignored. The second frame's snapshot replaces the first only at its own N+2.
